// File: rtl/dmem_responder_if.sv
// Request/response bundle for the data-memory port between the load/store unit and dmem_responder.
interface dmem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    en;
  logic                    we;
  logic [31:0]             addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    err;

  modport master (
    output en, we, addr, be, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  en, we, addr, be, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with byte-masked writes and fixed-latency pipelined reads.
// Define DMEM_RESP_RANGE_CHECK_EN to flag out-of-range accesses on err instead of wrapping.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [IdxW-1:0]       idx;
  logic                  oob;
  logic                  wr_req;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [LATENCY-1:0]                 valid_q;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] data_q;

  assign idx = bus.addr[IdxW+1:2];

  // Byte offset is the load/store unit's business; upper bits only matter for the range check.
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:IdxW+2], bus.addr[1:0]};

`ifdef DMEM_RESP_RANGE_CHECK_EN
  assign oob = (bus.addr >> (IdxW + 2)) != 32'd0;
`else
  assign oob = 1'b0;
`endif

  assign wr_req = bus.en & bus.we & ~oob;
  assign rd_req = bus.en & ~bus.we;

  always_comb begin
    rd_word = '0;
    if (!oob) rd_word = mem[idx];
  end

  // Array has no reset; the reset term only drops writes presented while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && wr_req) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Data stages load only alongside a valid bit so rdata holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= rd_req;
      if (rd_req) data_q[0] <= rd_word;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.rdata  = data_q[LATENCY-1];
  assign bus.rvalid = valid_q[LATENCY-1];

`ifdef DMEM_RESP_RANGE_CHECK_EN
  logic [LATENCY-1:0] err_q;
  logic               wr_err_q;

  // Read errors ride with the read pipeline; write errors pulse the cycle after the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      err_q[0] <= rd_req & oob;
      wr_err_q <= bus.en & bus.we & oob;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign bus.err = err_q[LATENCY-1] | wr_err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (two-cycle read latency).
module tb_dmem_responder;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dmem_responder_if #(.DATA_WIDTH(Dw)) bus ();

  dmem_responder #(
    .DATA_WIDTH (Dw),
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.be    = '0;
    bus.wdata = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic exp_err, input string tag);
    bus.en    = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.be    = b;
    bus.wdata = d;
    tick();
    idle();
    check_eq({tag, "_werr"}, {31'd0, bus.err}, {31'd0, exp_err});
    check_eq({tag, "_wvalid"}, {31'd0, bus.rvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_err,
                         input string tag);
    bus.en   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    tick();
    idle();
    for (int i = 1; i < Lat; i++) begin
      check_eq({tag, "_early"}, {31'd0, bus.rvalid}, 32'd0);
      tick();
    end
    check_eq({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
    check_eq({tag, "_rdata"}, bus.rdata, exp);
    check_eq({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    idle();

    #3;
    check_eq("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    check_eq("rst_err", {31'd0, bus.err}, 32'd0);
    tick();
    reset = 1'b1;

    // Full write then read on the next cycle
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "w10");
    do_read(32'h10, 32'hDEADBEEF, 1'b0, "r10");
    tick();
    check_eq("hold_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_eq("hold_rdata", bus.rdata, 32'hDEADBEEF);

    // Partial byte-enable write
    do_write(32'h20, 32'h11223344, 4'hF, 1'b0, "w20");
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "w20be");
    do_write(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, "w20nop");
    do_read(32'h23, 32'h11BB33DD, 1'b0, "r20");

    // Back-to-back reads
    for (int k = 0; k < 4; k++) do_write(32'(4 * k), 32'(k + 1), 4'hF, 1'b0, "wpre");
    for (int c = 0; c < 4 + Lat; c++) begin
      if (c < 4) begin
        bus.en   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'(4 * c);
      end else begin
        idle();
      end
      tick();
      if (c >= Lat - 1 && c - (Lat - 1) < 4) begin
        check_eq("b2b_rvalid", {31'd0, bus.rvalid}, 32'd1);
        check_eq("b2b_rdata", bus.rdata, 32'(c - (Lat - 1) + 1));
      end else begin
        check_eq("b2b_gap", {31'd0, bus.rvalid}, 32'd0);
      end
    end

    // Reset with a read in flight and a write presented during reset
    bus.en   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h10;
    tick();
    idle();
    reset = 1'b0;
    #1;
    check_eq("mrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_eq("mrst_rdata", bus.rdata, 32'd0);
    bus.en    = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h10;
    bus.be    = 4'hF;
    bus.wdata = 32'h0BAD0BAD;
    tick();
    idle();
    check_eq("mrst_rvalid2", {31'd0, bus.rvalid}, 32'd0);
    check_eq("mrst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < Lat + 1; i++) begin
      tick();
      check_eq("post_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      check_eq("post_rst_rdata", bus.rdata, 32'd0);
    end
    do_read(32'h10, 32'hDEADBEEF, 1'b0, "r10_post");

`ifdef DMEM_RESP_RANGE_CHECK_EN
    do_read(Depth * 4, 32'd0, 1'b1, "oob_read");
    tick();
    check_eq("oob_err_clr", {31'd0, bus.err}, 32'd0);
    do_write(Depth * 4, 32'h5A5A5A5A, 4'hF, 1'b1, "oob_write");
    do_read(32'h0, 32'd1, 1'b0, "r0_unchanged");
`else
    do_write(Depth * 4, 32'h5A5A5A5A, 4'hF, 1'b0, "wrap_write");
    do_read(32'h0, 32'h5A5A5A5A, 1'b0, "r0_wrapped");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
